// File: rtl/mul_issue_ctrl.sv
// Sequences RV32M multiplies onto the shared unsigned shift-add core,
// with sign correction, flush draining and a one-entry product cache.
module mul_issue_ctrl #(
    parameter bit CACHE_EN    = 1'b1,
    parameter bit ZERO_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        mul_start,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic        mul_ready,
    input  logic        mul_done,
    input  logic [63:0] mul_product
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BUSY,
        S_FIX,
        S_RESP,
        S_DRAIN
    } state_e;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] rs1_q, rs1_d;
    logic [31:0] rs2_q, rs2_d;
    logic        as_q, as_d;
    logic        bs_q, bs_d;
    logic        neg_q, neg_d;
    logic [31:0] mag_a_q, mag_a_d;
    logic [31:0] mag_b_q, mag_b_d;
    logic [63:0] prod_q, prod_d;
    logic [31:0] data_q, data_d;
    logic        cv_q, cv_d;
    logic [31:0] crs1_q, crs1_d;
    logic [31:0] crs2_q, crs2_d;
    logic        cas_q, cas_d;
    logic        cbs_q, cbs_d;
    logic [63:0] cp_q, cp_d;

    logic        accept;
    logic        a_sgn, b_sgn;
    logic        a_neg, b_neg;
    logic        hit, zero;
    logic        handoff;
    logic [63:0] p_fix;

    assign req_ready  = (state_q == S_IDLE) && !flush && !rst;
    assign resp_valid = (state_q == S_RESP) && !rst;
    assign mul_start  = (state_q == S_START) && !rst;
    assign resp_data  = data_q;
    assign mul_a      = mag_a_q;
    assign mul_b      = mag_b_q;

    assign accept  = req_valid && req_ready;
    assign a_sgn   = (req_op == OP_MULH) || (req_op == OP_MULHSU);
    assign b_sgn   = (req_op == OP_MULH);
    assign a_neg   = a_sgn && req_rs1[31];
    assign b_neg   = b_sgn && req_rs2[31];
    assign handoff = mul_ready && !mul_done;
    assign p_fix   = neg_q ? (64'd0 - prod_q) : prod_q;

    // Low half of a product does not depend on operand signedness.
    assign hit = CACHE_EN && cv_q
              && (crs1_q == req_rs1) && (crs2_q == req_rs2)
              && ((req_op == OP_MUL)
                  || ((a_sgn == cas_q) && (b_sgn == cbs_q)));
    assign zero = ZERO_BYPASS
               && ((req_rs1 == 32'd0) || (req_rs2 == 32'd0));

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        as_d    = as_q;
        bs_d    = bs_q;
        neg_d   = neg_q;
        mag_a_d = mag_a_q;
        mag_b_d = mag_b_q;
        prod_d  = prod_q;
        data_d  = data_q;
        cv_d    = cv_q;
        crs1_d  = crs1_q;
        crs2_d  = crs2_q;
        cas_d   = cas_q;
        cbs_d   = cbs_q;
        cp_d    = cp_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d    = req_op;
                    rs1_d   = req_rs1;
                    rs2_d   = req_rs2;
                    as_d    = a_sgn;
                    bs_d    = b_sgn;
                    neg_d   = a_neg ^ b_neg;
                    mag_a_d = a_neg ? (32'd0 - req_rs1) : req_rs1;
                    mag_b_d = b_neg ? (32'd0 - req_rs2) : req_rs2;
                    if (hit) begin
                        data_d  = (req_op == OP_MUL) ? cp_q[31:0]
                                                     : cp_q[63:32];
                        state_d = S_RESP;
                    end else if (zero) begin
                        data_d  = 32'd0;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                if (flush) begin
                    state_d = handoff ? S_DRAIN : S_IDLE;
                end else if (handoff) begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (flush) begin
                    state_d = mul_done ? S_IDLE : S_DRAIN;
                end else if (mul_done) begin
                    prod_d  = mul_product;
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                data_d = (op_q == OP_MUL) ? p_fix[31:0] : p_fix[63:32];
                if (CACHE_EN) begin
                    cv_d   = 1'b1;
                    crs1_d = rs1_q;
                    crs2_d = rs2_q;
                    cas_d  = as_q;
                    cbs_d  = bs_q;
                    cp_d   = p_fix;
                end
                state_d = flush ? S_IDLE : S_RESP;
            end
            S_RESP: begin
                if (flush || resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (mul_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 2'b00;
            rs1_q   <= 32'd0;
            rs2_q   <= 32'd0;
            as_q    <= 1'b0;
            bs_q    <= 1'b0;
            neg_q   <= 1'b0;
            mag_a_q <= 32'd0;
            mag_b_q <= 32'd0;
            prod_q  <= 64'd0;
            data_q  <= 32'd0;
            cv_q    <= 1'b0;
            crs1_q  <= 32'd0;
            crs2_q  <= 32'd0;
            cas_q   <= 1'b0;
            cbs_q   <= 1'b0;
            cp_q    <= 64'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            as_q    <= as_d;
            bs_q    <= bs_d;
            neg_q   <= neg_d;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            prod_q  <= prod_d;
            data_q  <= data_d;
            cv_q    <= cv_d;
            crs1_q  <= crs1_d;
            crs2_q  <= crs2_d;
            cas_q   <= cas_d;
            cbs_q   <= cbs_d;
            cp_q    <= cp_d;
        end
    end

endmodule

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
- Sequencer between the EX stage and the shared unsigned shift-add multiplier core.
- Executes RV32M MUL/MULH/MULHSU/MULHU: converts signed operands to magnitudes, starts the core, sign-corrects the 64-bit product and returns the selected 32-bit half.
- Handles pipeline flush while the core is busy.
- Shortcuts zero operands and back-to-back same-operand pairs (MULH followed by MUL) through a one-entry result cache.

Parameters:
- CACHE_EN, 1: enable the one-entry product cache.
- ZERO_BYPASS, 1: enable the zero-operand shortcut.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high; same rst as the multiplier core
- req_valid  in  1  EX presents a multiply
- req_ready  out  1  controller accepts request this cycle
- req_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- req_rs1  in  32  operand a
- req_rs2  in  32  operand b
- flush  in  1  kill in-flight op
- resp_valid  out  1  result available
- resp_ready  in  1  EX consumes result
- resp_data  out  32  result
- mul_start  out  1  to core start
- mul_a  out  32  to core multiplicand (magnitude)
- mul_b  out  32  to core multiplier (magnitude)
- mul_ready  in  1  core idle
- mul_done  in  1  core one-cycle done pulse
- mul_product  in  64  core unsigned product

Behaviour:
- Reset values:
  - req_ready=0 during rst, 1 in IDLE after.
  - resp_valid=0, resp_data=0, mul_start=0, mul_a=mul_b=0.
  - Cache valid=0; state=IDLE.
- Accept: req_valid & req_ready & !flush. req_ready=1 only in IDLE with flush=0. Operands and op are registered at accept.
- Signs:
  - a_neg = (op==01 | op==10) & rs1[31]
  - b_neg = (op==01) & rs2[31]
  - Magnitude = neg ? 32-bit two's negate : value; 0x80000000 maps to itself.
  - res_neg = a_neg ^ b_neg.
- Result:
  - P = res_neg ? 64-bit negate(mul_product) : mul_product.
  - resp_data = P[31:0] for MUL, else P[63:32].
- States:
  - IDLE: on accept:
    - cache hit → RESP (result from cache);
    - else zero operand (rs1==0 or rs2==0, ZERO_BYPASS) → RESP with P=0;
    - else → START.
  - START: mul_start=1. Advance to BUSY on the edge where mul_ready=1 & mul_done=0; the core latches operands on that edge. mul_start=0 in every other state.
  - BUSY: wait for mul_done; register mul_product → FIX.
  - FIX: compute P; register P and resp_data. Write cache with rs1, rs2, a_signed, b_signed, P; valid=1. → RESP.
  - RESP: resp_valid=1, resp_data stable until resp_ready. On resp_valid & resp_ready → IDLE. The next request is accepted no earlier than the following cycle.
  - DRAIN: req_ready=0; wait for mul_done, discard product, no cache write → IDLE.
- Latency (accept edge = cycle 0):
  - Hit/zero: resp_valid in cycle 1.
  - Core path: resp_valid 2 cycles after the mul_done cycle, +1 cycle for START.
- Cache hit condition:
  - valid, rs1 match, rs2 match, and either:
    - op==MUL (low half is signedness-independent), or
    - request signedness (a_signed, b_signed) equals the stored pair.
  - Otherwise the core path is taken.
- Flush, highest priority:
  - In IDLE: blocks accept.
  - In START before handoff: → IDLE.
  - In START on the handoff edge, or in BUSY: → DRAIN. A mul_done in the same cycle → IDLE.
  - In FIX: cache write still occurs, no response → IDLE.
  - In RESP: resp_valid drops next cycle → IDLE.
  - In DRAIN: no effect.
- Reset mid-operation: all state cleared to reset values; no response emitted; the core resets concurrently.
- mul_a/mul_b are driven from registered magnitudes and held constant from START through BUSY.

Test Plan:
- MUL 7×6 → resp_data=0x0000002A; mul_start seen once; resp_valid held across 3 cycles of resp_ready=0.
- MULH rs1=rs2=0xFFFFFFFF → magnitudes 1,1, res_neg=0, resp_data=0x00000000.
- MULHSU rs1=rs2=0xFFFFFFFF → P=0xFFFFFFFF_00000001, resp_data=0xFFFFFFFF. MULHU same operands → P=0xFFFFFFFE_00000001, resp_data=0xFFFFFFFE (cache miss: signedness differs).
- MULH 0x80000000×0x80000000 → resp_data=0x40000000. Then MUL same operands → cache hit, resp_valid in cycle 1, resp_data=0x00000000, no mul_start.
- MUL rs1=0, rs2=0x12345678 → resp_valid cycle 1, resp_data=0, no mul_start.
- MULHU 0xFFFFFFFF×0xFFFFFFFF with flush asserted 3 cycles into BUSY:
  - DRAIN entered, req_ready=0 until the cycle after mul_done.
  - No resp_valid, no cache write.
  - Next MUL 3×5 → 0x0000000F.
  - rst pulsed in BUSY on a repeat → all outputs at reset values next cycle.
